// File: rtl/data_mem_resp.sv
// Word-organised data memory for a CPU load/store stage.
// Byte/half/word stores with lane merging, registered loads (latency 1) with
// zero-filled right-justified data, write-first on same-cycle store+load,
// sticky misalignment reporting, access counters and a debug read port.
module data_mem_resp #(
  parameter int unsigned ADDR_BITS = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_w,
  input  logic                 mem_r,
  input  logic [31:0]          Addr_in,
  input  logic [31:0]          Data_in,
  input  logic [2:0]           DMType,
  output logic [31:0]          Data_out,
  output logic                 data_valid,
  output logic                 misalign_err,
  output logic [31:0]          err_addr,
  output logic [15:0]          load_cnt,
  output logic [15:0]          store_cnt,
  input  logic [ADDR_BITS-1:0] dbg_addr,
  output logic [31:0]          dbg_data
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    SZ_WORD,
    SZ_HALF,
    SZ_BYTE
  } size_e;

  logic [31:0]          mem [DEPTH];
  size_e                size;
  logic [ADDR_BITS-1:0] idx;
  logic                 misaligned;
  logic                 st_ok;
  logic                 ld_ok;
  logic [3:0]           byte_en;
  logic [31:0]          wr_lanes;
  logic [31:0]          cur_word;
  logic [31:0]          wr_word;
  logic [31:0]          rd_word;
  logic [31:0]          ld_data;

  // Decode access size (unused encodings fall back to word) and alignment.
  always_comb begin
    size       = SZ_WORD;
    misaligned = 1'b0;
    unique case (DMType)
      3'b001, 3'b010: size = SZ_HALF;
      3'b011, 3'b100: size = SZ_BYTE;
      default:        size = SZ_WORD;
    endcase
    unique case (size)
      SZ_HALF: misaligned = Addr_in[0];
      SZ_BYTE: misaligned = 1'b0;
      default: misaligned = (Addr_in[1:0] != 2'b00);
    endcase
    idx   = Addr_in[ADDR_BITS+1:2];
    st_ok = mem_w & ~misaligned;
    ld_ok = mem_r & ~misaligned;
  end

  // Build the merged store word; the load path sees it when a store to the
  // same word is accepted in the same cycle (both share Addr_in).
  always_comb begin
    byte_en  = '0;
    wr_lanes = '0;
    unique case (size)
      SZ_HALF: begin
        byte_en  = Addr_in[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{Data_in[15:0]}};
      end
      SZ_BYTE: begin
        byte_en  = 4'b0001 << Addr_in[1:0];
        wr_lanes = {4{Data_in[7:0]}};
      end
      default: begin
        byte_en  = 4'b1111;
        wr_lanes = Data_in;
      end
    endcase
    cur_word = mem[idx];
    wr_word  = cur_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (byte_en[b]) begin
        wr_word[8*b +: 8] = wr_lanes[8*b +: 8];
      end
    end
    rd_word = st_ok ? wr_word : cur_word;
  end

  // Extract the addressed lane(s) to bit 0; misaligned loads return zero.
  always_comb begin
    ld_data = '0;
    if (ld_ok) begin
      unique case (size)
        SZ_HALF: ld_data = {16'h0000, rd_word[{Addr_in[1], 4'b0000} +: 16]};
        SZ_BYTE: ld_data = {24'h000000, rd_word[{Addr_in[1:0], 3'b000} +: 8]};
        default: ld_data = rd_word;
      endcase
    end
  end

  // Memory array: cleared on reset, written by accepted stores.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (st_ok) begin
      mem[idx] <= wr_word;
    end
  end

  // Load response register: valid for one cycle after every load request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      Data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= mem_r;
      if (mem_r) begin
        Data_out <= ld_data;
      end
    end
  end

  // Sticky misalignment flag with first-offender address capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      misalign_err <= 1'b0;
      err_addr     <= '0;
    end else if ((mem_r | mem_w) & misaligned) begin
      misalign_err <= 1'b1;
      if (!misalign_err) begin
        err_addr <= Addr_in;
      end
    end
  end

  // Wrapping counters of accepted loads and stores.
  always_ff @(posedge clk) begin
    if (!rst) begin
      load_cnt  <= '0;
      store_cnt <= '0;
    end else begin
      if (ld_ok) load_cnt  <= load_cnt + 16'd1;
      if (st_ok) store_cnt <= store_cnt + 16'd1;
    end
  end

  // Combinational debug view of one memory word.
  always_comb begin
    dbg_data = mem[dbg_addr];
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: loads push their expected data into a
// queue, a negedge monitor pops on data_valid and checks hold behaviour.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_w = 1'b0;
  logic        mem_r = 1'b0;
  logic [31:0] Addr_in = '0;
  logic [31:0] Data_in = '0;
  logic [2:0]  DMType = '0;
  logic [31:0] Data_out;
  logic        data_valid;
  logic        misalign_err;
  logic [31:0] err_addr;
  logic [15:0] load_cnt;
  logic [15:0] store_cnt;
  logic [6:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_out = '0;
  logic        mon_en = 1'b0;
  logic        rst_q = 1'b0;

  data_mem_resp #(.ADDR_BITS(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_w        (mem_w),
    .mem_r        (mem_r),
    .Addr_in      (Addr_in),
    .Data_in      (Data_in),
    .DMType       (DMType),
    .Data_out     (Data_out),
    .data_valid   (data_valid),
    .misalign_err (misalign_err),
    .err_addr     (err_addr),
    .load_cnt     (load_cnt),
    .store_cnt    (store_cnt),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_q <= rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // One request cycle; a load pushes its expected response.
  task automatic issue(input logic w, input logic r, input logic [31:0] addr,
                       input logic [31:0] data, input logic [2:0] dmt,
                       input logic [31:0] exp_rd);
    mem_w   = w;
    mem_r   = r;
    Addr_in = addr;
    Data_in = data;
    DMType  = dmt;
    if (r) exp_q.push_back(exp_rd);
    @(posedge clk);
    #1;
    mem_w = 1'b0;
    mem_r = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic dbg(input string name, input logic [6:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(name, dbg_data, exp);
  endtask

  // Monitor: response data on data_valid, hold value otherwise.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!rst_q) begin
          last_out = '0;
          chk("valid_after_reset", {31'b0, data_valid}, 32'd0);
          chk("data_after_reset", Data_out, 32'd0);
        end else if (data_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid actual=0x%08h required=no_valid", Data_out);
          end else begin
            e = exp_q.pop_front();
            chk("load_data", Data_out, e);
            last_out = e;
          end
        end else begin
          chk("valid_known", {31'b0, data_valid}, 32'd0);
          chk("hold_data", Data_out, last_out);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    mon_en = 1'b1;
    chk("rst_valid", {31'b0, data_valid}, 32'd0);
    chk("rst_err", {31'b0, misalign_err}, 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    chk("rst_load_cnt", {16'b0, load_cnt}, 32'd0);
    chk("rst_store_cnt", {16'b0, store_cnt}, 32'd0);

    // Word store then word load.
    issue(1, 0, 32'h10, 32'hDEADBEEF, 3'b000, '0);
    issue(0, 1, 32'h10, '0, 3'b000, 32'hDEADBEEF);
    chk("cnt_store_1", {16'b0, store_cnt}, 32'd1);
    chk("cnt_load_1", {16'b0, load_cnt}, 32'd1);

    // Byte store into the same word, back-to-back byte/half loads.
    issue(1, 0, 32'h13, 32'h000000AA, 3'b011, '0);
    issue(0, 1, 32'h13, '0, 3'b100, 32'h000000AA);
    issue(0, 1, 32'h12, '0, 3'b001, 32'h0000AAAD);
    dbg("dbg_word4", 7'd4, 32'hAAADBEEF);
    chk("cnt_store_2", {16'b0, store_cnt}, 32'd2);
    chk("cnt_load_3", {16'b0, load_cnt}, 32'd3);
    idle(2);

    // Misaligned half store suppressed, flag and address captured.
    issue(1, 0, 32'h21, 32'h00001234, 3'b001, '0);
    dbg("dbg_word8", 7'd8, 32'h0);
    chk("mis_flag", {31'b0, misalign_err}, 32'd1);
    chk("mis_addr", err_addr, 32'h21);
    chk("mis_store_cnt", {16'b0, store_cnt}, 32'd2);
    issue(0, 1, 32'h22, '0, 3'b000, 32'h0);
    chk("mis_addr_kept", err_addr, 32'h21);
    chk("mis_load_cnt", {16'b0, load_cnt}, 32'd3);

    // Same-cycle store and load: write-first.
    issue(1, 1, 32'h40, 32'h12345678, 3'b000, 32'h12345678);
    issue(1, 1, 32'h42, 32'hFFFFBEEF, 3'b010, 32'h0000BEEF);
    issue(0, 1, 32'h40, '0, 3'b000, 32'hBEEF5678);
    chk("cnt_store_4", {16'b0, store_cnt}, 32'd4);
    chk("cnt_load_6", {16'b0, load_cnt}, 32'd6);

    // Address wrap modulo 0x200.
    issue(1, 0, 32'h200, 32'hFFFFFF55, 3'b100, '0);
    issue(0, 1, 32'h000, '0, 3'b011, 32'h00000055);
    dbg("dbg_word0", 7'd0, 32'h00000055);

    // DMType 111/101 behave as word; 110 word access misaligned.
    issue(1, 0, 32'h204, 32'hCAFEF00D, 3'b111, '0);
    issue(0, 1, 32'h004, '0, 3'b101, 32'hCAFEF00D);
    issue(0, 1, 32'h006, '0, 3'b110, 32'h0);
    chk("mis_addr_first_only", err_addr, 32'h21);

    // Half store to upper lanes ignores Data_in[31:16].
    issue(1, 0, 32'h46, 32'hFFFF1234, 3'b001, '0);
    dbg("dbg_word17", 7'd17, 32'h12340000);
    issue(0, 1, 32'h46, '0, 3'b010, 32'h00001234);
    idle(3);

    // Load, then reset with requests present.
    issue(0, 1, 32'h10, '0, 3'b000, 32'hAAADBEEF);
    rst     = 1'b0;
    mem_r   = 1'b1;
    mem_w   = 1'b1;
    Addr_in = 32'h8;
    Data_in = 32'h11111111;
    DMType  = 3'b000;
    @(posedge clk);
    #1;
    rst   = 1'b1;
    mem_r = 1'b0;
    mem_w = 1'b0;
    idle(1);
    chk("post_rst_valid", {31'b0, data_valid}, 32'd0);
    chk("post_rst_err", {31'b0, misalign_err}, 32'd0);
    chk("post_rst_err_addr", err_addr, 32'd0);
    chk("post_rst_load_cnt", {16'b0, load_cnt}, 32'd0);
    chk("post_rst_store_cnt", {16'b0, store_cnt}, 32'd0);
    chk("post_rst_data", Data_out, 32'd0);
    for (int i = 0; i < 128; i++) begin
      dbg("post_rst_dbg", 7'(i), 32'h0);
    end
    idle(2);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL missing_valid actual=%0d_pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
